golden_nonce_queue: RTL and testbench

//   Buffers golden nonces found by the hashing core until the host comm link can take them.

---
 rtl/golden_nonce_queue.sv | 113 +++++++++++
 tb/tb_golden_nonce_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_queue.sv
// Golden-nonce queue: buffers found nonces with their job tag for the comm link.
// Registered first-word-fall-through head, duplicate filter, and loss accounting.
module golden_nonce_queue #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int JOB_W  = 8
) (
   input  logic              hash_clk,
   input  logic              hash_rst_n,
   input  logic              rx_new_nonce,
   input  logic [31:0]       rx_golden_nonce,
   input  logic [JOB_W-1:0]  rx_job_id,
   input  logic              rx_flush,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [31:0]       tx_nonce,
   output logic [JOB_W-1:0]  tx_job_id,
   output logic [ADDR_W:0]   tx_count,
   output logic              tx_overflow,
   output logic [15:0]       tx_dropped
);

   logic [31:0]       mem_nonce [DEPTH];
   logic [JOB_W-1:0]  mem_job   [DEPTH];
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_nxt;
   logic [ADDR_W:0]   count;
   logic              hist_v;
   logic [31:0]       last_nonce;
   logic [JOB_W-1:0]  last_job;

   logic dup;
   logic attempt;
   logic full;
   logic pop;
   logic push;
   logic lost;

   always_comb begin
      dup     = hist_v & (rx_golden_nonce == last_nonce)
                & (rx_job_id == last_job);
      attempt = rx_new_nonce & ~dup & ~rx_flush;
      full    = (count == (ADDR_W+1)'(DEPTH));
      pop     = tx_valid & tx_ready & ~rx_flush;
      push    = attempt & (~full | pop);
      lost    = attempt & full & ~pop;
      rd_nxt  = rd_ptr + 1'b1;
   end

   assign tx_valid = (count != '0);
   assign tx_count = count;

   // Storage holds every queued entry, including the one mirrored in the head register.
   always_ff @(posedge hash_clk) begin
      if (push) begin
         mem_nonce[wr_ptr] <= rx_golden_nonce;
         mem_job[wr_ptr]   <= rx_job_id;
      end
   end

   always_ff @(posedge hash_clk or negedge hash_rst_n) begin
      if (!hash_rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         hist_v      <= 1'b0;
         last_nonce  <= '0;
         last_job    <= '0;
         tx_overflow <= 1'b0;
         tx_dropped  <= '0;
         tx_nonce    <= '0;
         tx_job_id   <= '0;
      end else if (rx_flush) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         hist_v      <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_nxt;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (attempt) begin
            hist_v     <= 1'b1;
            last_nonce <= rx_golden_nonce;
            last_job   <= rx_job_id;
         end
         if (lost) begin
            tx_overflow <= 1'b1;
            if (tx_dropped != 16'hFFFF) tx_dropped <= tx_dropped + 1'b1;
         end
         // Reload head when it leaves or when the queue was empty.
         if (pop) begin
            if (count > (ADDR_W+1)'(1)) begin
               tx_nonce  <= mem_nonce[rd_nxt];
               tx_job_id <= mem_job[rd_nxt];
            end else if (push) begin
               tx_nonce  <= rx_golden_nonce;
               tx_job_id <= rx_job_id;
            end
         end else if (count == '0 && push) begin
            tx_nonce  <= rx_golden_nonce;
            tx_job_id <= rx_job_id;
         end
      end
   end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Bench for golden_nonce_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_golden_nonce_queue;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int JOB_W  = 8;

   logic              hash_clk = 1'b0;
   logic              hash_rst_n = 1'b0;
   logic              rx_new_nonce = 1'b0;
   logic [31:0]       rx_golden_nonce = '0;
   logic [JOB_W-1:0]  rx_job_id = '0;
   logic              rx_flush = 1'b0;
   logic              tx_valid;
   logic              tx_ready = 1'b0;
   logic [31:0]       tx_nonce;
   logic [JOB_W-1:0]  tx_job_id;
   logic [ADDR_W:0]   tx_count;
   logic              tx_overflow;
   logic [15:0]       tx_dropped;

   golden_nonce_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .JOB_W(JOB_W)) dut (
      .hash_clk        (hash_clk),
      .hash_rst_n      (hash_rst_n),
      .rx_new_nonce    (rx_new_nonce),
      .rx_golden_nonce (rx_golden_nonce),
      .rx_job_id       (rx_job_id),
      .rx_flush        (rx_flush),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .tx_nonce        (tx_nonce),
      .tx_job_id       (tx_job_id),
      .tx_count        (tx_count),
      .tx_overflow     (tx_overflow),
      .tx_dropped      (tx_dropped)
   );

   always #5 hash_clk = ~hash_clk;

   typedef struct {
      logic [31:0]      n;
      logic [JOB_W-1:0] j;
   } ent_t;

   ent_t             q[$];
   bit               m_hv;
   logic [31:0]      m_ln;
   logic [JOB_W-1:0] m_lj;
   bit               m_ovf;
   int               m_drop;
   int               tests = 0;
   int               fails = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_hv = 0; m_ln = '0; m_lj = '0; m_ovf = 0; m_drop = 0;
   endtask

   task automatic model_edge(input logic nw, input logic [31:0] n,
                             input logic [JOB_W-1:0] j,
                             input logic fl, input logic rd);
      bit pop, dup;
      ent_t e;
      if (fl) begin
         q.delete();
         m_hv = 0;
         m_ovf = 0;
         return;
      end
      pop = (q.size() > 0) && rd;
      dup = m_hv && (n == m_ln) && (j == m_lj);
      if (pop) void'(q.pop_front());
      if (nw && !dup) begin
         m_hv = 1; m_ln = n; m_lj = j;
         if (q.size() >= DEPTH) begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
         end else begin
            e.n = n; e.j = j;
            q.push_back(e);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 64'(tx_valid), 64'(q.size() > 0));
      check({tag, ".count"}, 64'(tx_count), 64'(q.size()));
      check({tag, ".ovf"}, 64'(tx_overflow), 64'(m_ovf));
      check({tag, ".drop"}, 64'(tx_dropped), 64'(m_drop));
      if (q.size() > 0) begin
         check({tag, ".nonce"}, 64'(tx_nonce), 64'(q[0].n));
         check({tag, ".job"}, 64'(tx_job_id), 64'(q[0].j));
      end
   endtask

   task automatic step(input string tag, input logic nw, input logic [31:0] n,
                       input logic [JOB_W-1:0] j, input logic fl, input logic rd);
      @(negedge hash_clk);
      rx_new_nonce = nw; rx_golden_nonce = n; rx_job_id = j;
      rx_flush = fl; tx_ready = rd;
      @(posedge hash_clk);
      model_edge(nw, n, j, fl, rd);
      #1;
      check_outputs(tag);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < DEPTH + 2; k++) step(tag, 1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      model_reset();
      hash_rst_n = 1'b0;
      #23;
      check("rst.nonce", 64'(tx_nonce), 64'h0);
      check("rst.job", 64'(tx_job_id), 64'h0);
      check_outputs("rst");
      @(negedge hash_clk);
      hash_rst_n = 1'b1;

      step("t1.push", 1'b1, 32'h1234_5678, 8'd3, 1'b0, 1'b1);
      step("t1.pop", 1'b0, '0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 9; i++)
         step("t2.fill", 1'b1, 32'hC0DE_0000 + i, 8'd1, 1'b0, 1'b0);
      drain("t2.drain");

      for (int i = 0; i < 8; i++)
         step("t3.fill", 1'b1, 32'hBEEF_0000 + i, 8'd2, 1'b0, 1'b0);
      step("t3.pp", 1'b1, 32'hBEEF_00FF, 8'd2, 1'b0, 1'b1);
      drain("t3.drain");

      step("t4.a", 1'b1, 32'hAA, 8'd1, 1'b0, 1'b0);
      step("t4.dup", 1'b1, 32'hAA, 8'd1, 1'b0, 1'b0);
      step("t4.job", 1'b1, 32'hAA, 8'd4, 1'b0, 1'b0);
      drain("t4.drain");

      for (int i = 0; i < 5; i++)
         step("t5.fill", 1'b1, 32'h5000 + i, 8'd5, 1'b0, 1'b0);
      step("t5.flush", 1'b1, 32'h5FFF, 8'd5, 1'b1, 1'b1);
      step("t5.idle", 1'b0, '0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 20; i++)
         step("t6", 1'b1, 32'h6000 + i, 8'd6, 1'b0, 1'(i % 2));
      for (int i = 0; i < 20; i++)
         step("t6.mix", 1'(i % 2), 32'h6100 + i, 8'd6, 1'b0, 1'b1);
      drain("t6.drain");

      for (int i = 0; i < 600; i++) begin
         int rdp;
         rdp = (i < 300) ? 4 : 1;
         step("rnd", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)),
              JOB_W'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, rdp) == 0));
      end

      for (int i = 0; i < 12; i++)
         step("pre_rst", 1'b1, 32'h7000 + i, 8'd7, 1'b0, 1'b0);
      @(negedge hash_clk);
      hash_rst_n = 1'b0;
      #1;
      model_reset();
      check("mrst.nonce", 64'(tx_nonce), 64'h0);
      check_outputs("mrst");
      @(negedge hash_clk);
      rx_new_nonce = 1'b0; rx_flush = 1'b0;
      hash_rst_n = 1'b1;
      step("post_rst", 1'b1, 32'h8888, 8'd8, 1'b0, 1'b0);
      drain("post_rst.drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
